// File: rtl/johnson_pkg.sv
// -----------------------------------------------------------------------------
// johnson_pkg
// Shared definitions for the Johnson-code decoder:
//   - johnson_state_e : decoder FSM states (UNLOCKED / LOCKED)
//   - seq_len()       : number of codes in a WIDTH-bit Johnson sequence
//   - idx_w()         : bit width needed to hold an index into that sequence
//   - idx_inc/idx_dec : modulo-SEQ_LEN step of an index (SEQ_LEN need not be
//                       a power of two, so plain wrap-around is not enough)
// -----------------------------------------------------------------------------
package johnson_pkg;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } johnson_state_e;

    function automatic int unsigned seq_len(input int unsigned width);
        return 32'd2 * width;
    endfunction

    function automatic int unsigned idx_w(input int unsigned width);
        return (seq_len(width) > 32'd1) ? $clog2(seq_len(width)) : 32'd1;
    endfunction

    function automatic int unsigned idx_inc(input int unsigned idx, input int unsigned n);
        return (idx >= n - 32'd1) ? 32'd0 : idx + 32'd1;
    endfunction

    function automatic int unsigned idx_dec(input int unsigned idx, input int unsigned n);
        return (idx == 32'd0) ? n - 32'd1 : idx - 32'd1;
    endfunction

endpackage

// File: rtl/johnson_index.sv
// -----------------------------------------------------------------------------
// johnson_index
// Purely combinational Johnson code classifier.
// Ports:
//   code_in   [WIDTH-1:0] : code under test
//   valid_o               : 1 when code_in is one of the SEQ_LEN legal codes
//   idx_o     [IDX_W-1:0] : index of the matching code (0 when not valid)
// -----------------------------------------------------------------------------
module johnson_index
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned SEQ_LEN = seq_len(WIDTH),
    localparam int unsigned IDX_W   = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] code_in,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH-1:0] legal_s;

    // Compare the input against every legal code. Indices 0..WIDTH fill ones
    // from the LSB; indices above WIDTH clear ones from the LSB again.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        legal_s = '0;
        for (int k = 0; k < int'(SEQ_LEN); k++) begin
            if (k <= int'(WIDTH)) begin
                legal_s = ONES >> (int'(WIDTH) - k);
            end else begin
                legal_s = ONES << (k - int'(WIDTH));
            end
            if (code_in == legal_s) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(k);
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/johnson_decoder.sv
// -----------------------------------------------------------------------------
// johnson_decoder
// Samples a WIDTH-bit Johnson code, decodes it to a binary index and classifies
// each qualified sample as forward step, backward step, hold or error.
// Optional feature macro: JOHNSON_DEC_POS_EN (net signed position counter).
// Ports:
//   clk, reset (sync, active-high)
//   sample_en  : qualifies code_in
//   code_in    : Johnson code under test
//   clr_err    : clears err_count / err_sticky (a simultaneous error wins)
//   index_out  : last valid decoded index
//   code_valid : last sample was legal
//   locked     : FSM is LOCKED
//   step_fwd / step_bwd / trans_err : one-cycle pulses
//   err_sticky, err_count : error statistics (count saturates)
//   pos_count  : net step count (0 unless JOHNSON_DEC_POS_EN is defined)
// -----------------------------------------------------------------------------
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ERR_CNT_W = 8,
    parameter int unsigned POS_W     = 16,
    localparam int unsigned SEQ_LEN  = seq_len(WIDTH),
    localparam int unsigned IDX_W    = idx_w(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic [WIDTH-1:0]     code_in,
    input  logic                 clr_err,
    output logic [IDX_W-1:0]     index_out,
    output logic                 code_valid,
    output logic                 locked,
    output logic                 step_fwd,
    output logic                 step_bwd,
    output logic                 trans_err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [POS_W-1:0]     pos_count
);

    johnson_state_e       state_q, state_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic                 valid_q, valid_d;
    logic                 fwd_q, fwd_d;
    logic                 bwd_q, bwd_d;
    logic                 err_q, err_d;
    logic                 sticky_q, sticky_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    logic                 code_ok_s;
    logic [IDX_W-1:0]     idx_s;
    logic [IDX_W-1:0]     prev_inc_s;
    logic [IDX_W-1:0]     prev_dec_s;

    johnson_index #(
        .WIDTH (WIDTH)
    ) u_index (
        .code_in (code_in),
        .valid_o (code_ok_s),
        .idx_o   (idx_s)
    );

    assign prev_inc_s = IDX_W'(idx_inc(32'(index_q), SEQ_LEN));
    assign prev_dec_s = IDX_W'(idx_dec(32'(index_q), SEQ_LEN));

    // FSM next state, decoded index and step/error pulses.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        valid_d = valid_q;
        fwd_d   = 1'b0;
        bwd_d   = 1'b0;
        err_d   = 1'b0;
        if (sample_en) begin
            valid_d = code_ok_s;
            case (state_q)
                UNLOCKED: begin
                    if (code_ok_s) begin
                        index_d = idx_s;
                        state_d = LOCKED;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (code_ok_s) begin
                        // Any legal code is adopted; a jump just resyncs.
                        index_d = idx_s;
                        if (idx_s == index_q) begin
                            fwd_d = 1'b0;
                        end else if (idx_s == prev_inc_s) begin
                            fwd_d = 1'b1;
                        end else if (idx_s == prev_dec_s) begin
                            bwd_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        // Index holds so the last good position stays visible.
                        err_d   = 1'b1;
                        state_d = UNLOCKED;
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Error statistics: a new error overrides a simultaneous clear.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (err_d) begin
            sticky_d = 1'b1;
            if (clr_err) begin
                cnt_d = ERR_CNT_W'(1);
            end else if (cnt_q != {ERR_CNT_W{1'b1}}) begin
                cnt_d = cnt_q + ERR_CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else if (clr_err) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= UNLOCKED;
            index_q  <= '0;
            valid_q  <= 1'b0;
            fwd_q    <= 1'b0;
            bwd_q    <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            valid_q  <= valid_d;
            fwd_q    <= fwd_d;
            bwd_q    <= bwd_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef JOHNSON_DEC_POS_EN
    logic [POS_W-1:0] pos_q, pos_d;

    // Net position follows the step pulses; clr_err does not touch it.
    always_comb begin
        if (fwd_d) begin
            pos_d = pos_q + POS_W'(1);
        end else if (bwd_d) begin
            pos_d = pos_q - POS_W'(1);
        end else begin
            pos_d = pos_q;
        end
    end

    // Position register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_count = pos_q;
`else
    assign pos_count = '0;
`endif

    assign index_out  = index_q;
    assign code_valid = valid_q;
    assign locked     = (state_q == LOCKED);
    assign step_fwd   = fwd_q;
    assign step_bwd   = bwd_q;
    assign trans_err  = err_q;
    assign err_sticky = sticky_q;
    assign err_count  = cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// -----------------------------------------------------------------------------
// tb_johnson_decoder
// Directed bench for johnson_decoder (WIDTH=4, ERR_CNT_W=2 so saturation is
// reachable in a few steps). Each step pushes the expected register state to a
// scoreboard queue, clocks once and pops/compares against the outputs.
// -----------------------------------------------------------------------------
module tb_johnson_decoder;

    typedef struct {
        string       tag;
        logic [31:0] idx;
        logic [31:0] valid;
        logic [31:0] lock;
        logic [31:0] fwd;
        logic [31:0] bwd;
        logic [31:0] err;
        logic [31:0] sticky;
        logic [31:0] cnt;
        logic [31:0] pos;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_en = 1'b0;
    logic [3:0]  code_in = 4'b0000;
    logic        clr_err = 1'b0;
    logic [2:0]  index_out;
    logic        code_valid;
    logic        locked;
    logic        step_fwd;
    logic        step_bwd;
    logic        trans_err;
    logic        err_sticky;
    logic [1:0]  err_count;
    logic [15:0] pos_count;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    johnson_decoder #(
        .WIDTH     (4),
        .ERR_CNT_W (2),
        .POS_W     (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_en  (sample_en),
        .code_in    (code_in),
        .clr_err    (clr_err),
        .index_out  (index_out),
        .code_valid (code_valid),
        .locked     (locked),
        .step_fwd   (step_fwd),
        .step_bwd   (step_bwd),
        .trans_err  (trans_err),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .pos_count  (pos_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, record its expected outcome, then compare.
    task automatic step(input string tag, input logic en, input logic [3:0] code, input logic clr,
                        input int e_idx, input int e_v, input int e_l, input int e_f, input int e_b,
                        input int e_e, input int e_s, input int e_c, input int e_p);
        exp_t e;
        exp_t o;
        sample_en = en;
        code_in   = code;
        clr_err   = clr;
        e.tag = tag;
        e.idx = e_idx; e.valid = e_v; e.lock = e_l; e.fwd = e_f; e.bwd = e_b;
        e.err = e_e; e.sticky = e_s; e.cnt = e_c;
`ifdef JOHNSON_DEC_POS_EN
        e.pos = e_p;
`else
        e.pos = (e_p == 0) ? 32'd0 : 32'd0;
`endif
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        n_tests++;
        assert (sb_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end
        if (sb_q.size() > 0) begin
            o = sb_q.pop_front();
            chk(o.tag, "index_out",  32'(index_out),  o.idx);
            chk(o.tag, "code_valid", 32'(code_valid), o.valid);
            chk(o.tag, "locked",     32'(locked),     o.lock);
            chk(o.tag, "step_fwd",   32'(step_fwd),   o.fwd);
            chk(o.tag, "step_bwd",   32'(step_bwd),   o.bwd);
            chk(o.tag, "trans_err",  32'(trans_err),  o.err);
            chk(o.tag, "err_sticky", 32'(err_sticky), o.sticky);
            chk(o.tag, "err_count",  32'(err_count),  o.cnt);
            chk(o.tag, "pos_count",  32'(pos_count),  o.pos);
        end
    endtask

    initial begin
        // Reset wins over sample_en and clr_err.
        reset = 1'b1;
        step("rst",      1'b1, 4'b0101, 1'b1, 0,1'b0,0,0,0,0,0,0,0);
        reset = 1'b0;
        //    tag         en    code     clr   idx v l f b e s c pos
        // 1: lock then count up
        step("t1_lock",  1'b1, 4'b0000, 1'b0, 0, 1,1,0,0,0,0,0,0);
        step("t1_s1",    1'b1, 4'b0001, 1'b0, 1, 1,1,1,0,0,0,0,1);
        step("t1_s2",    1'b1, 4'b0011, 1'b0, 2, 1,1,1,0,0,0,0,2);
        step("t1_s3",    1'b1, 4'b0111, 1'b0, 3, 1,1,1,0,0,0,0,3);
        step("t1_s4",    1'b1, 4'b1111, 1'b0, 4, 1,1,1,0,0,0,0,4);
        // 2: reach idx7 and cross the wrap both ways
        step("t2_s5",    1'b1, 4'b1110, 1'b0, 5, 1,1,1,0,0,0,0,5);
        step("t2_s6",    1'b1, 4'b1100, 1'b0, 6, 1,1,1,0,0,0,0,6);
        step("t2_s7",    1'b1, 4'b1000, 1'b0, 7, 1,1,1,0,0,0,0,7);
        step("t2_wrapf", 1'b1, 4'b0000, 1'b0, 0, 1,1,1,0,0,0,0,8);
        step("t2_wrapb", 1'b1, 4'b1000, 1'b0, 7, 1,1,0,1,0,0,0,7);
        step("t2_fwd0",  1'b1, 4'b0000, 1'b0, 0, 1,1,1,0,0,0,0,8);
        step("t2_hold",  1'b1, 4'b0000, 1'b0, 0, 1,1,0,0,0,0,0,8);
        // 3: illegal code while locked, then relock
        step("t3_s1",    1'b1, 4'b0001, 1'b0, 1, 1,1,1,0,0,0,0,9);
        step("t3_s2",    1'b1, 4'b0011, 1'b0, 2, 1,1,1,0,0,0,0,10);
        step("t3_bad",   1'b1, 4'b0101, 1'b0, 2, 0,0,0,0,1,1,1,10);
        step("t3_relck", 1'b1, 4'b0111, 1'b0, 3, 1,1,0,0,0,1,1,10);
        // 4: illegal jump while locked, then sample_en=0 holds
        step("t4_b2",    1'b1, 4'b0011, 1'b0, 2, 1,1,0,1,0,1,1,9);
        step("t4_b1",    1'b1, 4'b0001, 1'b0, 1, 1,1,0,1,0,1,1,8);
        step("t4_jump",  1'b1, 4'b0111, 1'b0, 3, 1,1,0,0,1,1,2,8);
        step("t4_idle1", 1'b0, 4'b1111, 1'b0, 3, 1,1,0,0,0,1,2,8);
        step("t4_idle2", 1'b0, 4'b0000, 1'b0, 3, 1,1,0,0,0,1,2,8);
        // 5: saturation, clear-vs-error, plain clear
        step("t5_e1",    1'b1, 4'b0101, 1'b0, 3, 0,0,0,0,1,1,3,8);
        step("t5_e2",    1'b1, 4'b1010, 1'b0, 3, 0,0,0,0,1,1,3,8);
        step("t5_e3",    1'b1, 4'b0110, 1'b0, 3, 0,0,0,0,1,1,3,8);
        step("t5_e4",    1'b1, 4'b1001, 1'b0, 3, 0,0,0,0,1,1,3,8);
        step("t5_e5",    1'b1, 4'b1011, 1'b0, 3, 0,0,0,0,1,1,3,8);
        step("t5_e6",    1'b1, 4'b1101, 1'b0, 3, 0,0,0,0,1,1,3,8);
        step("t5_clre",  1'b1, 4'b0100, 1'b1, 3, 0,0,0,0,1,1,1,8);
        step("t5_clr",   1'b0, 4'b0100, 1'b1, 3, 0,0,0,0,0,0,0,8);
        // 6: fresh position count, then reset mid-stream
        reset = 1'b1;
        step("t6_rst",   1'b0, 4'b0000, 1'b0, 0, 0,0,0,0,0,0,0,0);
        reset = 1'b0;
        step("t6_lock",  1'b1, 4'b0000, 1'b0, 0, 1,1,0,0,0,0,0,0);
        step("t6_f1",    1'b1, 4'b0001, 1'b0, 1, 1,1,1,0,0,0,0,1);
        step("t6_f2",    1'b1, 4'b0011, 1'b0, 2, 1,1,1,0,0,0,0,2);
        step("t6_f3",    1'b1, 4'b0111, 1'b0, 3, 1,1,1,0,0,0,0,3);
        step("t6_f4",    1'b1, 4'b1111, 1'b0, 4, 1,1,1,0,0,0,0,4);
        step("t6_f5",    1'b1, 4'b1110, 1'b0, 5, 1,1,1,0,0,0,0,5);
        step("t6_b1",    1'b1, 4'b1111, 1'b0, 4, 1,1,0,1,0,0,0,4);
        step("t6_b2",    1'b1, 4'b0111, 1'b0, 3, 1,1,0,1,0,0,0,3);
        step("t6_clr",   1'b0, 4'b0111, 1'b1, 3, 1,1,0,0,0,0,0,3);
        reset = 1'b1;
        step("t6_midrst",1'b1, 4'b0011, 1'b1, 0, 0,0,0,0,0,0,0,0);
        reset = 1'b0;
        step("t6_after", 1'b0, 4'b0011, 1'b0, 0, 0,0,0,0,0,0,0,0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/johnson_decoder.md
Name: johnson_decoder

Overview:
Receive-side counterpart of the Johnson counter: samples a WIDTH-bit Johnson code and decodes it to a binary index. It classifies each sample as a forward step, a backward step, a hold or an error, and keeps error statistics. It sits between a Johnson source (counter output, SW bank or GPIO) and the LEDR/HEX display logic on the DE1_SoC.

Parameters:
WIDTH, 4, Johnson register width; the sequence length is SEQ_LEN = 2*WIDTH.
ERR_CNT_W, 8, width of the saturating error counter.
POS_W, 16, width of the position counter (optional feature only).

Ports:
clk  in  1  system clock; one clock domain.
reset  in  1  synchronous, active-high reset.
sample_en  in  1  qualifies code_in; the block acts only on edges where this is 1.
code_in  in  WIDTH  Johnson code under test.
clr_err  in  1  synchronous clear of err_count and err_sticky.
index_out  out  IDX_W=$clog2(SEQ_LEN)  last valid decoded index.
code_valid  out  1  last sample was a legal Johnson code.
locked  out  1  FSM is in LOCKED.
step_fwd  out  1  one-cycle pulse: index advanced by +1 mod SEQ_LEN.
step_bwd  out  1  one-cycle pulse: index moved by -1 mod SEQ_LEN.
trans_err  out  1  one-cycle pulse: illegal code or illegal jump.
err_sticky  out  1  set by any error; held until reset or clr_err.
err_count  out  ERR_CNT_W  saturating error count.
pos_count  out  POS_W  net signed step count (optional feature only).

Behaviour:
- Legal codes: for k in 0..WIDTH, code = (1<<k)-1. For k in WIDTH+1..SEQ_LEN-1, code = ~((1<<(k-WIDTH))-1), masked to WIDTH bits.
- WIDTH=4 sequence: 0000,0001,0011,0111,1111,1110,1100,1000 map to index 0..7.
- Reset: all outputs 0, FSM goes to UNLOCKED.
- Latency: all outputs are registered and reflect the sample taken on the edge where sample_en=1. Pulses last exactly one cycle.
- sample_en=0: no state change, all pulses 0, other outputs hold.
- FSM UNLOCKED, valid sample: index_out=idx, code_valid=1, go to LOCKED, no step pulse.
- FSM UNLOCKED, invalid sample: code_valid=0, trans_err=1, error recorded, stay UNLOCKED.
- FSM LOCKED, valid sample, compared against prev = index_out:
  - idx==prev: hold, no pulse.
  - idx==prev+1 mod SEQ_LEN: step_fwd.
  - idx==prev-1 mod SEQ_LEN: step_bwd.
  - any other idx: trans_err, error recorded, index_out=idx (resync), stay LOCKED.
- FSM LOCKED, invalid sample: code_valid=0, trans_err, error recorded, index_out holds, go to UNLOCKED.
- Wrap-around: the 7->0 transition is forward and 0->7 is backward (WIDTH=4).
- Error recorded: err_sticky=1 and err_count increments, saturating at 2^ERR_CNT_W-1.
- clr_err alone: err_count=0, err_sticky=0.
- clr_err together with a new error: the error wins; result is err_count=1, err_sticky=1.
- reset has priority over everything, including mid-sequence and while clr_err is asserted.

Optional Feature:
JOHNSON_DEC_POS_EN
- Defined: pos_count increments on step_fwd and decrements on step_bwd, two's-complement, wrapping modulo 2^POS_W. Reset value is 0; clr_err does not affect it.
- Undefined: pos_count is tied to 0 and no position logic is synthesised.

Decomposition:
- Package johnson_pkg holds:
  - the FSM state typedef {UNLOCKED, LOCKED};
  - SEQ_LEN and IDX_W helper functions;
  - the mod-SEQ_LEN increment/decrement functions.
- Sub-module johnson_index: purely combinational code -> {valid, idx}, parameterised by WIDTH. The top module holds the FSM, the counters and the registers.

Test Plan:
1. Reset, then sample_en=1 with 0000,0001,0011,0111,1111 -> locked=1 after the first sample with no pulse; then 4 step_fwd pulses; index_out 0,1,2,3,4; err_count=0.
2. From 1000 (idx7) feed 0000, then 1000 -> step_fwd with index 0, then step_bwd with index 7; 0000 repeated -> no pulses.
3. Locked at 0011, feed 0101 -> code_valid=0, trans_err 1 cycle, err_count=1, err_sticky=1, locked=0, index_out stays 2; then 0111 -> relock at idx3 with no step pulse.
4. Locked at 0001, feed 0111 -> trans_err, err_count+1, index_out=3, locked stays 1; sample_en=0 while code_in toggles -> outputs unchanged.
5. ERR_CNT_W=2, six errors -> err_count=3 (saturated). Then clr_err together with an error -> err_count=1, err_sticky=1. Then clr_err alone -> 0/0.
6. With JOHNSON_DEC_POS_EN: 5 forward then 2 backward steps -> pos_count=3; assert reset mid-stream -> all outputs 0 and locked=0 on the next cycle.
